seg7_scan: RTL
==============

// Module: seg7_scan
// PURPOSE
//  Scan sequencer directly upstream of the seg7 decoder. Holds one 3-bit pattern index per digit and
//  time-multiplexes them onto data1 (pattern index) and data2 (digit select, 1..NUM_DIG).
//  A blanking interval separates digits to suppress ghosting.
//  Writes go to a shadow buffer and are applied at frame boundaries so a frame never tears.
// PARAMETERS
//  DWELL      1000  cycles each digit is driven (>=1)
//  BLANK_CYC  16    blank cycles after each digit (0 = no blank state)
//  NUM_DIG    6     digits scanned, legal range 1..6
// PORTS
//  clk         in   1  single clock; all logic on rising edge
//  rst         in   1  reset, synchronous, active-high
//  en          in   1  1 = scan; 0 = idle, display blanked
//  wr_en       in   1  write strobe into shadow buffer
//  wr_addr     in   3  digit number 1..NUM_DIG; 0 or >NUM_DIG ignored
//  wr_data     in   3  pattern index for that digit
//  commit      in   1  1-cycle request: shadow -> active at next frame boundary
//  data1       out  3  pattern index to seg7.data1 (registered)
//  data2       out  3  digit select to seg7.data2; 0 = blank (registered)
//  commit_pend out  1  commit requested, not yet applied
//  frame_done  out  1  1-cycle pulse on last cycle of each frame
// BEHAVIOUR
//  Reset: data1=0, data2=0, commit_pend=0, frame_done=0, both buffers all-zero, state IDLE, counters 0.
//  Reset asserted mid-frame: all of the above at that edge; pending commit discarded.
//  States: IDLE, SHOW, BLANK. Cycle counter cnt, digit counter dig (1..NUM_DIG).
//  IDLE: data2=0, data1=0. en=1 -> SHOW, dig=1, cnt=0 at next edge.
//  SHOW: data2=dig, data1=active[dig], both registered on SHOW entry and held.
//    After DWELL cycles -> BLANK; if BLANK_CYC=0, go directly to the next digit.
//  BLANK: data2=0, data1=0 for BLANK_CYC cycles, then -> SHOW with dig+1.
//    After dig=NUM_DIG, wrap to dig=1.
//  Frame = NUM_DIG*(DWELL+BLANK_CYC) cycles.
//    frame_done=1 on the final cycle of digit NUM_DIG (last BLANK cycle, or last SHOW cycle if BLANK_CYC=0).
//  Frame boundary = the edge at which dig wraps NUM_DIG->1.
//    If (commit_pend|commit), active<=shadow and commit_pend<=0 at that edge.
//    The new digit 1 is displayed from the updated buffer.
//  commit outside a boundary: commit_pend<=1 at next edge. Repeated commits merge into one.
//  Write: wr_en with a valid addr updates shadow[wr_addr] at next edge.
//    The active buffer is never written directly.
//  Write and boundary copy in the same cycle: the copy uses the pre-edge shadow.
//    The new write lands in shadow only and needs a later commit.
//  en deasserted in SHOW or BLANK: -> IDLE at next edge, data2=0. A partial frame gives no frame_done.
//  In IDLE, a pending or incoming commit applies immediately at the next edge.
//  Re-enable always restarts at dig=1.
//  Outputs change only on state entry; no combinational path from inputs to outputs.
// TESTING
//  1 DWELL=4,BLANK_CYC=2,NUM_DIG=6; write d1..d6=1..6, commit, en=1 -> data2 runs 1,0,2,0..6,0.
//    Each nonzero value held 4 cycles, each 0 held 2; data1 = digit number; frame_done every 36 cycles.
//  2 Mid-frame, write d3=7 and pulse commit -> commit_pend=1; d3 still shows 3 this frame.
//    After the wrap, d3 shows 7 and commit_pend=0.
//  3 wr_en with wr_addr=0 and =7 (NUM_DIG=6) -> shadow unchanged.
//    Write+commit in the boundary cycle -> copy uses old shadow.
//  4 BLANK_CYC=0 -> data2 never 0 while en=1; frame_done on last SHOW cycle of d6.
//    NUM_DIG=1 -> data2 stays 1 with blanks between.
//  5 Drop en during d4 -> data2=0 next cycle, no frame_done.
//    Commit while idle -> applied next edge; re-enable starts at d1.
//  6 Assert rst during d5 with commit_pend=1 -> data1=data2=0, commit_pend=0 next edge, buffers zero.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: scan sequencer feeding the seg7 decoder.
// Holds one 3-bit pattern index per digit and time-multiplexes them onto
// data1_o (pattern index) and data2_o (digit select, 1..NUM_DIG, 0 = blank).
// A blanking interval after each digit suppresses ghosting. Host writes land
// in a shadow buffer and are copied to the active buffer only at a frame
// boundary (or while idle), so a displayed frame never tears.
//
// Handshake note: there is no valid/ready pairing here. wr_en_i is a
// single-cycle strobe accepted unconditionally on the rising edge when
// wr_addr_i is in 1..NUM_DIG; commit_i is a single-cycle request whose
// acceptance is visible as commit_pend_o until the copy happens.
//
// All outputs are registered; state_o exposes the FSM state for checkers.

module seg7_scan #(
  parameter int DWELL     = 1000, // cycles each digit is driven (>= 1)
  parameter int BLANK_CYC = 16,   // blank cycles after each digit (0 = none)
  parameter int NUM_DIG   = 6     // digits scanned, 1..6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [2:0] wr_data_i,
  input  logic       commit_i,
  output logic [2:0] data1_o,
  output logic [2:0] data2_o,
  output logic       commit_pend_o,
  output logic       frame_done_o,
  output logic [1:0] state_o
);

  // Counter must hold the larger of the two interval lengths minus one.
  localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  // When there is no blank state this value is never compared against.
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [2:0]       DIG_LAST   = 3'(NUM_DIG);
  localparam int               BUF_W      = 3 * NUM_DIG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2:0]         dig_q,   dig_d;
  logic [2:0]         data1_q, data1_d;
  logic [2:0]         data2_q, data2_d;
  logic               pend_q,  pend_d;
  logic               fd_q,    fd_d;
  logic [BUF_W-1:0]   shadow_q, shadow_d;
  logic [BUF_W-1:0]   active_q, active_d;

  // Combinational control shared between the FSM and buffer logic.
  logic               load;     // a new digit is being entered at this edge
  logic               wrap;     // dig goes NUM_DIG -> 1 at this edge
  logic               copy;     // shadow -> active at this edge
  logic [2:0]         nxt_dig;

  // Selects the 3-bit entry for digit number d (1-based) from a buffer.
  function automatic logic [2:0] pick(input logic [BUF_W-1:0] bank,
                                      input logic [2:0]       d);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (d == 3'(i + 1)) r = bank[i*3 +: 3];
    end
    return r;
  endfunction

  // Scan FSM: next state, counters and the registered display values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    data1_d = data1_q;
    data2_d = data2_q;
    load    = 1'b0;
    wrap    = 1'b0;
    copy    = 1'b0;
    fd_d    = 1'b0;
    nxt_dig = (dig_q == DIG_LAST) ? 3'd1 : (dig_q + 3'd1);

    case (state_q)
      IDLE: begin
        data1_d = '0;
        data2_d = '0;
        cnt_d   = '0;
        if (en_i) begin
          // Re-enable always restarts the scan from digit 1.
          state_d = SHOW;
          dig_d   = 3'd1;
          load    = 1'b1;
        end
      end

      SHOW: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          data1_d = '0;
          data2_d = '0;
        end else if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYC > 0) begin
            state_d = BLANK;
            data1_d = '0;
            data2_d = '0;
          end else begin
            // No blank state: step straight to the next digit.
            dig_d = nxt_dig;
            wrap  = (dig_q == DIG_LAST);
            load  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BLANK: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          data1_d = '0;
          data2_d = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          dig_d   = nxt_dig;
          wrap    = (dig_q == DIG_LAST);
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        data1_d = '0;
        data2_d = '0;
      end
    endcase

    // Copy happens at a frame boundary, or at any edge while idle.
    copy = (pend_q | commit_i) & ((state_q == IDLE) | wrap);

    // The digit entered at a boundary is shown from the freshly copied data.
    if (load) begin
      data2_d = dig_d;
      data1_d = pick(copy ? shadow_q : active_q, dig_d);
    end

    // Flag the cycle that will be the last one of the frame.
    if (BLANK_CYC > 0) begin
      fd_d = (state_d == BLANK) && (cnt_d == BLANK_LAST) && (dig_d == DIG_LAST);
    end else begin
      fd_d = (state_d == SHOW) && (cnt_d == DWELL_LAST) && (dig_d == DIG_LAST);
    end
  end

  // Buffers and commit tracking: writes go to shadow only; the copy uses
  // the pre-edge shadow so a simultaneous write needs a later commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;

    if (copy) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (commit_i) begin
      pend_d   = 1'b1;
    end

    if (wr_en_i) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (wr_addr_i == 3'(i + 1)) shadow_d[i*3 +: 3] = wr_data_i;
      end
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dig_q    <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      pend_q   <= 1'b0;
      fd_q     <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign data1_o       = data1_q;
  assign data2_o       = data2_q;
  assign commit_pend_o = pend_q;
  assign frame_done_o  = fd_q;
  assign state_o       = state_q;

endmodule
